cop1_issue_ctrl: RTL
====================

COP1_ISSUE_CTRL -- requirements
Module: cop1_issue_ctrl

Interface
REQ-001 SHALL have parameter LAT_ADD, default 2: execute cycles for FP_ADD/FP_SUB.
REQ-002 SHALL have parameter LAT_MUL, default 3: execute cycles for FP_MUL.
REQ-003 SHALL have parameter LAT_DIV, default 8: execute cycles for FP_DIV; all other ALU codes take 1 cycle.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; ports are listed below.
- clk  in  1  rising-edge clock.
- rst_b  in  1  reset, asynchronous, active low.
- halted  in  1  processor halted; blocks new issue.
- issue_valid  in  1  pipeline offers an FP instruction.
- issue_ready  out  1  controller accepts the instruction this cycle.
- issue_op  in  5  operation code (package encoding).
- issue_fs, issue_ft, issue_fd  in  5 each  FP register numbers.
- issue_int_data  in  32  integer operand for FP_MTC.
- fs_num, ft_num  out  5 each  regfile read addresses (= issue_fs/issue_ft, combinational).
- fs_data, ft_data  in  32 each  regfile read data (combinational).
- alu_a, alu_b  out  32 each  latched FP ALU operands.
- alu_control  out  5  latched FP ALU operation.
- alu_result  in  32  FP ALU result (combinational).
- wb_fd  out  5  FP writeback register.
- wb_data  out  32  FP writeback data.
- wb_we  out  1  FP register write enable.
- int_result  out  32  FP_MFC result for the integer pipeline.
- int_valid  out  1  int_result valid strobe.
- stall  out  1  pipeline stall request.
- busy  out  1  operation in flight.

Function
REQ-005 SHALL implement states IDLE, EXEC, WB.
REQ-006 SHALL drive issue_ready = (state==IDLE) && !halted.
REQ-007 On accept (issue_valid && issue_ready), SHALL latch fs_data, ft_data, issue_op, issue_fd, and issue_int_data.
- FP_MTC or FP_MFC: next state WB.
- Other codes: next state EXEC with counter = latency-1.
REQ-008 In EXEC, SHALL drive alu_a/alu_b/alu_control from latches and decrement the counter each cycle.
- When counter==0, SHALL capture alu_result into wb_data and go to WB.
REQ-009 In WB, SHALL remain exactly one cycle and then go to IDLE.
- FP_MTC: wb_we=1, wb_data = latched int data.
- FP_MFC: int_valid=1, int_result = latched fs_data, wb_we=0.
- All other codes: wb_we=1.
REQ-010 Accept-to-wb_we latency SHALL be LAT+1 cycles for arithmetic ops and 1 cycle for FP_MTC/FP_MFC.
REQ-011 wb_we and int_valid SHALL be single-cycle pulses; wb_fd, wb_data, and int_result SHALL hold their values until the next WB.
REQ-012 stall SHALL equal issue_valid && !issue_ready; busy SHALL equal (state!=IDLE).
REQ-013 No issue SHALL be accepted in WB, so an operand read never races a writeback to the same register.
REQ-014 halted asserted mid-operation SHALL NOT abort the operation: it completes through WB, and no further ops are accepted.
REQ-015 Data paths SHALL be 32-bit with no width conversion; the latency counter SHALL be wide enough for max(LAT_*)-1.
REQ-016 An unknown issue_op SHALL be treated as a 1-cycle ALU operation.

Reset
REQ-017 Reset SHALL be asynchronous on rst_b low.
- Reset values: state=IDLE, counter=0, all latches 0.
- Outputs: wb_we=0, int_valid=0, busy=0, wb_data=0, int_result=0, wb_fd=0.
REQ-018 Reset asserted mid-EXEC or mid-WB SHALL discard the operation, with no writeback or int_valid after release.

Structure
REQ-019 A shared package SHALL hold the op codes: FP_ADD=0, FP_SUB=1, FP_MUL=2, FP_DIV=3, FP_MTC=4, FP_MFC=5.
- The package SHALL also hold the state enum and the default latency constants.
REQ-020 The latency lookup SHALL be one sub-module, fp_lat_lookup (op -> counter preload); everything else is flat.

Verification
REQ-021 FP_ADD of fs=0x3FC00000 and ft=0x40100000, fd=3:
- Required: wb_we pulses at accept+3 with wb_fd=3 and wb_data=0x40700000.
- Required: busy is high for 3 cycles.
REQ-022 FP_DIV, with issue_valid held through the operation:
- Required: stall is high for 9 cycles; wb_we at accept+9.
- Required: the second instruction is accepted the cycle after WB.
REQ-023 FP_MTC with issue_int_data=0xDEADBEEF, fd=7:
- Required: wb_we at accept+1 with wb_data=0xDEADBEEF and wb_fd=7.
REQ-024 FP_MFC with fs_data=0x12345678:
- Required: int_valid at accept+1 with int_result=0x12345678 and wb_we=0.
REQ-025 halted raised during FP_MUL:
- Required: the MUL still writes back; issue_ready stays 0 while halted.
REQ-026 rst_b low for 1 cycle mid-FP_DIV:
- Required: all outputs return to 0 immediately.
- Required: no wb_we occurs afterwards, and issue_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/cop1_issue_ctrl_pkg.sv
// Shared definitions for the COP1 (FP coprocessor) issue controller:
// operation codes, controller states and default execute latencies.
package cop1_issue_ctrl_pkg;

  localparam logic [4:0] FP_ADD = 5'd0;
  localparam logic [4:0] FP_SUB = 5'd1;
  localparam logic [4:0] FP_MUL = 5'd2;
  localparam logic [4:0] FP_DIV = 5'd3;
  localparam logic [4:0] FP_MTC = 5'd4;
  localparam logic [4:0] FP_MFC = 5'd5;

  localparam int DEF_LAT_ADD = 2;
  localparam int DEF_LAT_MUL = 3;
  localparam int DEF_LAT_DIV = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Register transfers skip the ALU and go straight to writeback.
  function automatic logic is_xfer(input logic [4:0] op);
    return (op == FP_MTC) || (op == FP_MFC);
  endfunction

endpackage

// File: rtl/cop1_issue_ctrl_if.sv
// Pipeline <-> COP1 issue controller bundle: issue handshake, regfile read
// port, FP ALU hookup, FP writeback and integer result return.
interface cop1_issue_ctrl_if;

  logic        halted;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_op;
  logic [4:0]  issue_fs;
  logic [4:0]  issue_ft;
  logic [4:0]  issue_fd;
  logic [31:0] issue_int_data;
  logic [4:0]  fs_num;
  logic [4:0]  ft_num;
  logic [31:0] fs_data;
  logic [31:0] ft_data;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_control;
  logic [31:0] alu_result;
  logic [4:0]  wb_fd;
  logic [31:0] wb_data;
  logic        wb_we;
  logic [31:0] int_result;
  logic        int_valid;
  logic        stall;
  logic        busy;

  modport slave (
    input  halted, issue_valid, issue_op, issue_fs, issue_ft, issue_fd,
           issue_int_data, fs_data, ft_data, alu_result,
    output issue_ready, fs_num, ft_num, alu_a, alu_b, alu_control,
           wb_fd, wb_data, wb_we, int_result, int_valid, stall, busy
  );

  modport master (
    output halted, issue_valid, issue_op, issue_fs, issue_ft, issue_fd,
           issue_int_data, fs_data, ft_data, alu_result,
    input  issue_ready, fs_num, ft_num, alu_a, alu_b, alu_control,
           wb_fd, wb_data, wb_we, int_result, int_valid, stall, busy
  );

endinterface

// File: rtl/cop1_issue_ctrl_fp_lat_lookup.sv
// Maps an FP operation code to the execute-counter preload (latency - 1).
// Unknown codes and register transfers preload zero.
module fp_lat_lookup
  import cop1_issue_ctrl_pkg::*;
#(
  parameter int LAT_ADD = DEF_LAT_ADD,
  parameter int LAT_MUL = DEF_LAT_MUL,
  parameter int LAT_DIV = DEF_LAT_DIV,
  parameter int CNT_W   = 3
) (
  input  logic [4:0]       i_op,
  output logic [CNT_W-1:0] o_cnt
);

  // Latency table lookup.
  always_comb begin
    o_cnt = {CNT_W{1'b0}};
    case (i_op)
      FP_ADD, FP_SUB: o_cnt = CNT_W'(LAT_ADD - 1);
      FP_MUL:         o_cnt = CNT_W'(LAT_MUL - 1);
      FP_DIV:         o_cnt = CNT_W'(LAT_DIV - 1);
      default:        o_cnt = {CNT_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/cop1_issue_ctrl.sv
// COP1 issue controller: accepts one FP instruction at a time, sequences it
// through a fixed-latency execute phase and a single writeback cycle.
module cop1_issue_ctrl
  import cop1_issue_ctrl_pkg::*;
#(
  parameter int LAT_ADD = DEF_LAT_ADD,
  parameter int LAT_MUL = DEF_LAT_MUL,
  parameter int LAT_DIV = DEF_LAT_DIV
) (
  input  logic             clk,
  input  logic             rst_b,
  cop1_issue_ctrl_if.slave bus
);

  localparam int MAX_LAT = max3(LAT_ADD, LAT_MUL, LAT_DIV);
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_pre;
  logic [31:0]      r_fs_data;
  logic [31:0]      r_ft_data;
  logic [4:0]       r_op;
  logic [4:0]       r_fd;
  logic             r_wb_we;
  logic             r_int_valid;
  logic [31:0]      r_wb_data;
  logic [31:0]      r_int_result;
  logic [4:0]       r_wb_fd;
  logic             w_ready;
  logic             w_accept;
  logic             w_exec_done;

  // Issue is blocked in EXEC and WB so operand reads never race a writeback.
  assign w_ready     = (r_state == ST_IDLE) && !bus.halted;
  assign w_accept    = bus.issue_valid && w_ready;
  assign w_exec_done = (r_state == ST_EXEC) && (r_cnt == {CNT_W{1'b0}});

  fp_lat_lookup #(
    .LAT_ADD (LAT_ADD),
    .LAT_MUL (LAT_MUL),
    .LAT_DIV (LAT_DIV),
    .CNT_W   (CNT_W)
  ) u_lat (
    .i_op  (bus.issue_op),
    .o_cnt (w_cnt_pre)
  );

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = is_xfer(bus.issue_op) ? ST_WB : ST_EXEC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (w_exec_done) begin
          w_state_nxt = ST_WB;
        end else begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_WB:   w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register, latency counter and operand latches.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state   <= ST_IDLE;
      r_cnt     <= {CNT_W{1'b0}};
      r_fs_data <= 32'd0;
      r_ft_data <= 32'd0;
      r_op      <= 5'd0;
      r_fd      <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt     <= w_cnt_pre;
        r_fs_data <= bus.fs_data;
        r_ft_data <= bus.ft_data;
        r_op      <= bus.issue_op;
        r_fd      <= bus.issue_fd;
      end else if ((r_state == ST_EXEC) && !w_exec_done) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // Writeback/result registers, loaded on the edge that enters WB so the
  // strobes are high exactly for the WB cycle; data holds until the next load.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wb_we      <= 1'b0;
      r_int_valid  <= 1'b0;
      r_wb_data    <= 32'd0;
      r_wb_fd      <= 5'd0;
      r_int_result <= 32'd0;
    end else begin
      r_wb_we     <= 1'b0;
      r_int_valid <= 1'b0;
      if (w_accept && (bus.issue_op == FP_MTC)) begin
        r_wb_we   <= 1'b1;
        r_wb_data <= bus.issue_int_data;
        r_wb_fd   <= bus.issue_fd;
      end else if (w_accept && (bus.issue_op == FP_MFC)) begin
        r_int_valid  <= 1'b1;
        r_int_result <= bus.fs_data;
      end else if (w_exec_done) begin
        r_wb_we   <= 1'b1;
        r_wb_data <= bus.alu_result;
        r_wb_fd   <= r_fd;
      end
    end
  end

  assign bus.issue_ready = w_ready;
  assign bus.stall       = bus.issue_valid && !w_ready;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.fs_num      = bus.issue_fs;
  assign bus.ft_num      = bus.issue_ft;
  assign bus.alu_a       = r_fs_data;
  assign bus.alu_b       = r_ft_data;
  assign bus.alu_control = r_op;
  assign bus.wb_we       = r_wb_we;
  assign bus.wb_data     = r_wb_data;
  assign bus.wb_fd       = r_wb_fd;
  assign bus.int_valid   = r_int_valid;
  assign bus.int_result  = r_int_result;

endmodule
